spi_xact_ctrl: RTL and testbench
================================

# spi_xact_ctrl

Transaction sequencer sitting directly upstream of the SPI master and consuming its response. Accepts one host request {packet size, data}, programs the master's packet-size interface, pushes the data word to the master, waits for the received word, masks it to the packet size and returns it to the host. Serializes transactions, one outstanding at a time.

## Interface

- nbits, 34, SPI word width, same as master
- sw, $clog2(nbits), packet-size field width (6 at default)

- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; low forces reset state immediately
- req_val  in  1  host request valid
- req_rdy  out  1  host request ready
- req_size  in  sw  requested packet length in bits
- req_data  in  nbits  word to shift out on MOSI
- resp_val  out  1  host response valid
- resp_rdy  in  1  host response ready
- resp_msg  out  nbits  masked received word
- pkt_size_val  out  1  to master packet_size_ifc_val
- pkt_size_rdy  in  1  from master packet_size_ifc_rdy
- pkt_size_msg  out  sw  to master packet_size_ifc_msg
- spi_req_val  out  1  to master recv_val
- spi_req_rdy  in  1  from master recv_rdy
- spi_req_msg  out  nbits  to master recv_msg
- spi_resp_val  in  1  from master send_val
- spi_resp_rdy  out  1  to master send_rdy
- spi_resp_msg  in  nbits  from master send_msg
- busy  out  1  high in any state other than IDLE
- xact_count  out  8  completed transactions, wraps 255 -> 0

## Operation

- States: IDLE, SIZE, DATA, WAIT, RESP. Reset state IDLE.
- IDLE: req_rdy=1. On req_val: register effective size and req_data; go SIZE (or DATA if size cache hit, see Configuration).
- Effective size: req_size in 1..nbits used as-is; 0 or >nbits saturates to nbits.
- SIZE: pkt_size_val=1, pkt_size_msg=registered size; on pkt_size_rdy go DATA.
- DATA: spi_req_val=1, spi_req_msg=registered data; on spi_req_rdy go WAIT.
- WAIT: spi_resp_rdy=1; on spi_resp_val capture spi_resp_msg with bits [nbits-1:size] zeroed into resp register; go RESP.
- RESP: resp_val=1; on resp_rdy increment xact_count, go IDLE.
- Every val is a pure decode of state; a val, once raised, stays high with stable msg until the matching rdy.
- spi_resp_val outside WAIT is ignored (spi_resp_rdy=0, nothing captured).
- Reset outputs: req_rdy=1, resp_val=0, pkt_size_val=0, spi_req_val=0, spi_resp_rdy=0, busy=0, xact_count=0, resp_msg=0, pkt_size_msg=0, spi_req_msg=0.
- Reset asserted mid-transaction: abandon immediately, return to IDLE, drop held response, clear size cache.

## Timing

- Request accepted on the edge where req_val & req_rdy; SIZE asserted the next cycle.
- Each state transition takes the edge on which its handshake fires; no bubble between states.
- Best case (all rdy high, cache miss): accept at cycle 0, size fires cycle 1, data fires cycle 2, WAIT from cycle 3; response captured at edge N; resp_val high from cycle N+1.
- req_rdy is low from the cycle after acceptance until the cycle after the response handshake; no back-to-back accept in the RESP-fire cycle.
- xact_count and busy update on the RESP handshake edge.

## Configuration

- SPI_XACT_SIZE_CACHE_EN defined: controller holds last programmed size plus valid flag (cleared on reset). An accepted request whose effective size equals the cached value skips SIZE and enters DATA directly. Cache updated on each pkt_size handshake.
- Not defined: SIZE is entered for every request; no cache state exists.

## Test plan

- Basic: size=8, data=34'h0_0000_00A5, master stub returns 34'h3_FFFF_FF3C -> pkt_size_msg=8, spi_req_msg=34'hA5, resp_msg=34'h3C, xact_count=1.
- Saturation: req_size=0 then req_size=40 -> pkt_size_msg=34 both times, resp_msg unmasked.
- Backpressure: hold pkt_size_rdy, spi_req_rdy, resp_rdy low 5 cycles each -> vals stay high, msgs stable, no state skip, req_rdy low throughout.
- Cache (macro on): two requests size=16 -> one pkt_size handshake total; third with size=12 -> handshake with 12. Macro off -> three handshakes.
- Reset in WAIT: pulse reset low for 1 cycle -> all outputs at reset values, busy=0, next size=16 request issues SIZE even with cache on.
- Wrap: 256 completed transactions -> xact_count returns to 0; stray spi_resp_val in IDLE -> no resp_val.

Source files
------------

// File: rtl/spi_xact_ctrl.sv
// spi_xact_ctrl: serializes host {size, data} requests onto an SPI master.
// Programs the master's packet size, pushes the data word, collects the
// received word, masks it to the packet size and returns it to the host.
// Optional build macro: SPI_XACT_SIZE_CACHE_EN skips reprogramming the packet
// size when the request's effective size matches the last programmed one.
module spi_xact_ctrl #(
  parameter int unsigned nbits = 34,
  parameter int unsigned sw    = $clog2(nbits)
) (
  input  logic             clk,
  input  logic             reset,
  // host request
  input  logic             req_val,
  output logic             req_rdy,
  input  logic [sw-1:0]    req_size,
  input  logic [nbits-1:0] req_data,
  // host response
  output logic             resp_val,
  input  logic             resp_rdy,
  output logic [nbits-1:0] resp_msg,
  // master packet-size interface
  output logic             pkt_size_val,
  input  logic             pkt_size_rdy,
  output logic [sw-1:0]    pkt_size_msg,
  // master transmit word
  output logic             spi_req_val,
  input  logic             spi_req_rdy,
  output logic [nbits-1:0] spi_req_msg,
  // master received word
  input  logic             spi_resp_val,
  output logic             spi_resp_rdy,
  input  logic [nbits-1:0] spi_resp_msg,
  // status
  output logic             busy,
  output logic [7:0]       xact_count
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SIZE = 3'd1,
    DATA = 3'd2,
    WAIT = 3'd3,
    RESP = 3'd4
  } state_t;

  state_t           state;
  logic [sw-1:0]    eff_size;
  logic [nbits-1:0] resp_mask;
  logic             cache_hit;

  // Out-of-range sizes (0 or above the word width) mean a full-width word.
  assign eff_size = ((req_size == '0) || (req_size > sw'(nbits))) ? sw'(nbits) : req_size;

  // Keep only the low pkt_size_msg bits; a full-width shift yields an all-ones mask.
  assign resp_mask = ~({nbits{1'b1}} << pkt_size_msg);

`ifdef SPI_XACT_SIZE_CACHE_EN
  logic [sw-1:0] cache_size;
  logic          cache_vld;

  assign cache_hit = cache_vld && (cache_size == eff_size);

  // Remember the size last accepted by the master.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cache_size <= '0;
      cache_vld  <= 1'b0;
    end else if (pkt_size_val && pkt_size_rdy) begin
      cache_size <= pkt_size_msg;
      cache_vld  <= 1'b1;
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  // Transaction sequencer; every val/rdy flag is registered alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      req_rdy      <= 1'b1;
      busy         <= 1'b0;
      pkt_size_val <= 1'b0;
      pkt_size_msg <= '0;
      spi_req_val  <= 1'b0;
      spi_req_msg  <= '0;
      spi_resp_rdy <= 1'b0;
      resp_val     <= 1'b0;
      resp_msg     <= '0;
      xact_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_val) begin
            pkt_size_msg <= eff_size;
            spi_req_msg  <= req_data;
            req_rdy      <= 1'b0;
            busy         <= 1'b1;
            if (cache_hit) begin
              state       <= DATA;
              spi_req_val <= 1'b1;
            end else begin
              state        <= SIZE;
              pkt_size_val <= 1'b1;
            end
          end
        end
        SIZE: begin
          if (pkt_size_rdy) begin
            state        <= DATA;
            pkt_size_val <= 1'b0;
            spi_req_val  <= 1'b1;
          end
        end
        DATA: begin
          if (spi_req_rdy) begin
            state        <= WAIT;
            spi_req_val  <= 1'b0;
            spi_resp_rdy <= 1'b1;
          end
        end
        WAIT: begin
          if (spi_resp_val) begin
            state        <= RESP;
            spi_resp_rdy <= 1'b0;
            resp_val     <= 1'b1;
            resp_msg     <= spi_resp_msg & resp_mask;
          end
        end
        RESP: begin
          if (resp_rdy) begin
            state      <= IDLE;
            resp_val   <= 1'b0;
            req_rdy    <= 1'b1;
            busy       <= 1'b0;
            xact_count <= xact_count + 8'd1;
          end
        end
        default: begin
          state        <= IDLE;
          req_rdy      <= 1'b1;
          busy         <= 1'b0;
          pkt_size_val <= 1'b0;
          spi_req_val  <= 1'b0;
          spi_resp_rdy <= 1'b0;
          resp_val     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xact_ctrl.sv
// Testbench for spi_xact_ctrl: table vectors, randomized transactions against
// a transaction-level model, and hand-written reset / wrap / cache sequences.
module tb_spi_xact_ctrl;

  localparam int unsigned NB = 34;
  localparam int unsigned SW = 6;

  logic          clk;
  logic          reset;
  logic          req_val, req_rdy;
  logic [SW-1:0] req_size;
  logic [NB-1:0] req_data;
  logic          resp_val, resp_rdy;
  logic [NB-1:0] resp_msg;
  logic          pkt_size_val, pkt_size_rdy;
  logic [SW-1:0] pkt_size_msg;
  logic          spi_req_val, spi_req_rdy;
  logic [NB-1:0] spi_req_msg;
  logic          spi_resp_val, spi_resp_rdy;
  logic [NB-1:0] spi_resp_msg;
  logic          busy;
  logic [7:0]    xact_count;

  spi_xact_ctrl dut (
    .clk(clk), .reset(reset),
    .req_val(req_val), .req_rdy(req_rdy), .req_size(req_size), .req_data(req_data),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_msg(resp_msg),
    .pkt_size_val(pkt_size_val), .pkt_size_rdy(pkt_size_rdy), .pkt_size_msg(pkt_size_msg),
    .spi_req_val(spi_req_val), .spi_req_rdy(spi_req_rdy), .spi_req_msg(spi_req_msg),
    .spi_resp_val(spi_resp_val), .spi_resp_rdy(spi_resp_rdy), .spi_resp_msg(spi_resp_msg),
    .busy(busy), .xact_count(xact_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Transaction-level model state
  logic [7:0] model_count = 8'd0;
  int         hs_cnt      = 0;
`ifdef SPI_XACT_SIZE_CACHE_EN
  bit         cache_vld   = 1'b0;
  logic [5:0] cache_sz    = 6'd0;
`endif

  typedef struct {
    logic [5:0]  size;
    logic [33:0] data;
    logic [33:0] rword;
    int          stall;
    logic [5:0]  exp_size;
    logic [33:0] exp_resp;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Spec rule: 0 or > word width means full width.
  function automatic logic [5:0] eff_f(input logic [5:0] s);
    int v;
    v = int'(s);
    if (v == 0 || v > 34) v = 34;
    return 6'(v);
  endfunction

  // Low-bit extraction using modulo arithmetic.
  function automatic logic [33:0] mask_f(input logic [33:0] w, input logic [5:0] s);
    longint unsigned m;
    m = longint'(1) << s;
    return 34'(64'(w) % m);
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".req_rdy"},      64'(req_rdy), 64'd1);
    chk({tag, ".resp_val"},     64'(resp_val), 64'd0);
    chk({tag, ".pkt_size_val"}, 64'(pkt_size_val), 64'd0);
    chk({tag, ".spi_req_val"},  64'(spi_req_val), 64'd0);
    chk({tag, ".spi_resp_rdy"}, 64'(spi_resp_rdy), 64'd0);
    chk({tag, ".busy"},         64'(busy), 64'd0);
    chk({tag, ".xact_count"},   64'(xact_count), 64'd0);
    chk({tag, ".resp_msg"},     64'(resp_msg), 64'd0);
    chk({tag, ".pkt_size_msg"}, 64'(pkt_size_msg), 64'd0);
    chk({tag, ".spi_req_msg"},  64'(spi_req_msg), 64'd0);
  endtask

  // One-cycle asynchronous reset pulse; model forgets everything.
  task automatic pulse_reset(input string tag);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_reset_vals({tag, ".during"});
    @(negedge clk);
    reset = 1'b1;
    spi_resp_val = 1'b0;
    pkt_size_rdy = 1'b0;
    spi_req_rdy  = 1'b0;
    resp_rdy     = 1'b0;
    #1;
    chk_reset_vals({tag, ".after"});
    model_count = 8'd0;
`ifdef SPI_XACT_SIZE_CACHE_EN
    cache_vld = 1'b0;
`endif
  endtask

  // Full transaction with 'stall' cycles of backpressure at every handshake.
  // With abort set, the transaction is killed by a reset pulse in WAIT.
  task automatic xact(input logic [5:0] size, input logic [33:0] data, input logic [33:0] rword,
                      input int stall, input logic [5:0] exp_size, input logic [33:0] exp_resp,
                      input bit abort);
    bit exp_hs;
`ifdef SPI_XACT_SIZE_CACHE_EN
    exp_hs = !(cache_vld && (cache_sz == exp_size));
`else
    exp_hs = 1'b1;
`endif
    @(negedge clk);
    chk("accept.req_rdy", 64'(req_rdy), 64'd1);
    req_val = 1'b1; req_size = size; req_data = data;
    @(negedge clk);
    req_val = 1'b0; req_size = 6'($urandom()); req_data = 34'({$urandom(), $urandom()});
    if (exp_hs) begin
      for (int i = 0; i <= stall; i++) begin
        chk("size.val", 64'(pkt_size_val), 64'd1);
        chk("size.msg", 64'(pkt_size_msg), 64'(exp_size));
        chk("size.spi_req_val", 64'(spi_req_val), 64'd0);
        chk("size.req_rdy", 64'(req_rdy), 64'd0);
        chk("size.busy", 64'(busy), 64'd1);
        pkt_size_rdy = (i == stall);
        @(negedge clk);
      end
      pkt_size_rdy = 1'b0;
      hs_cnt++;
`ifdef SPI_XACT_SIZE_CACHE_EN
      cache_vld = 1'b1;
      cache_sz  = exp_size;
`endif
    end
    for (int i = 0; i <= stall; i++) begin
      chk("data.val", 64'(spi_req_val), 64'd1);
      chk("data.msg", 64'(spi_req_msg), 64'(data));
      chk("data.pkt_size_val", 64'(pkt_size_val), 64'd0);
      chk("data.req_rdy", 64'(req_rdy), 64'd0);
      spi_req_rdy = (i == stall);
      @(negedge clk);
    end
    spi_req_rdy = 1'b0;
    if (abort) begin
      chk("abort.spi_resp_rdy", 64'(spi_resp_rdy), 64'd1);
      spi_resp_val = 1'b1;
      spi_resp_msg = rword;
      pulse_reset("abort");
      return;
    end
    for (int i = 0; i <= stall; i++) begin
      chk("wait.rdy", 64'(spi_resp_rdy), 64'd1);
      chk("wait.spi_req_val", 64'(spi_req_val), 64'd0);
      chk("wait.resp_val", 64'(resp_val), 64'd0);
      spi_resp_val = (i == stall);
      spi_resp_msg = (i == stall) ? rword : 34'({$urandom(), $urandom()});
      @(negedge clk);
    end
    spi_resp_val = 1'b0;
    for (int i = 0; i <= stall; i++) begin
      chk("resp.val", 64'(resp_val), 64'd1);
      chk("resp.msg", 64'(resp_msg), 64'(exp_resp));
      chk("resp.spi_resp_rdy", 64'(spi_resp_rdy), 64'd0);
      chk("resp.req_rdy", 64'(req_rdy), 64'd0);
      chk("resp.count", 64'(xact_count), 64'(model_count));
      resp_rdy = (i == stall);
      @(negedge clk);
    end
    resp_rdy = 1'b0;
    model_count = model_count + 8'd1;
    chk("done.resp_val", 64'(resp_val), 64'd0);
    chk("done.req_rdy", 64'(req_rdy), 64'd1);
    chk("done.busy", 64'(busy), 64'd0);
    chk("done.count", 64'(xact_count), 64'(model_count));
  endtask

  initial begin
    logic [5:0]  sz;
    logic [33:0] d, r;
    int          hs0;

    tbl[0] = '{6'd8,  34'h0_0000_00A5, 34'h3_FFFF_FF3C, 0, 6'd8,  34'h0_0000_003C};
    tbl[1] = '{6'd0,  34'h1_2345_6789, 34'h2_DEAD_BEEF, 1, 6'd34, 34'h2_DEAD_BEEF};
    tbl[2] = '{6'd40, 34'h3_0000_0001, 34'h3_FFFF_FFFF, 5, 6'd34, 34'h3_FFFF_FFFF};
    tbl[3] = '{6'd1,  34'h0_0000_0001, 34'h3_FFFF_FFFE, 2, 6'd1,  34'h0_0000_0000};
    tbl[4] = '{6'd33, 34'h2_5A5A_5A5A, 34'h3_FFFF_FFFF, 0, 6'd33, 34'h1_FFFF_FFFF};
    tbl[5] = '{6'd35, 34'h0_CAFE_F00D, 34'h2_AAAA_5555, 3, 6'd34, 34'h2_AAAA_5555};
    tbl[6] = '{6'd16, 34'h0_0000_BEEF, 34'h3_1234_ABCD, 1, 6'd16, 34'h0_0000_ABCD};

    reset = 1'b0; req_val = 1'b0; req_size = '0; req_data = '0;
    resp_rdy = 1'b0; pkt_size_rdy = 1'b0; spi_req_rdy = 1'b0;
    spi_resp_val = 1'b0; spi_resp_msg = '0;
    @(negedge clk); @(negedge clk);
    chk_reset_vals("por");
    reset = 1'b1;

    for (int i = 0; i < 7; i++)
      xact(tbl[i].size, tbl[i].data, tbl[i].rword, tbl[i].stall, tbl[i].exp_size, tbl[i].exp_resp, 1'b0);

    for (int i = 0; i < 40; i++) begin
      sz = 6'($urandom_range(63, 0));
      if (i % 4 == 1) sz = 6'(eff_f(sz));
      d = 34'({$urandom(), $urandom()});
      r = 34'({$urandom(), $urandom()});
      xact(sz, d, r, int'($urandom_range(3, 0)), eff_f(sz), mask_f(r, eff_f(sz)), 1'b0);
    end

    // Stray master response while idle must be ignored.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      spi_resp_val = 1'b1; spi_resp_msg = 34'h1_1111_1111;
      chk("stray.spi_resp_rdy", 64'(spi_resp_rdy), 64'd0);
      chk("stray.resp_val", 64'(resp_val), 64'd0);
      chk("stray.busy", 64'(busy), 64'd0);
    end
    @(negedge clk);
    spi_resp_val = 1'b0;
    chk("stray.resp_val_end", 64'(resp_val), 64'd0);
    chk("stray.count", 64'(xact_count), 64'(model_count));

    // Size cache: 16, 16, 12 from a clean reset.
    pulse_reset("pre_cache");
    hs0 = hs_cnt;
    xact(6'd16, 34'h0_0000_1234, 34'h3_FFFF_0F0F, 0, 6'd16, 34'h0_0000_0F0F, 1'b0);
    xact(6'd16, 34'h0_0000_5678, 34'h0_ABCD_EF01, 2, 6'd16, 34'h0_0000_EF01, 1'b0);
    xact(6'd12, 34'h0_0000_0ABC, 34'h3_FFFF_FFFF, 0, 6'd12, 34'h0_0000_0FFF, 1'b0);
`ifdef SPI_XACT_SIZE_CACHE_EN
    chk("cache.hs_count", 64'(hs_cnt - hs0), 64'd2);
`else
    chk("cache.hs_count", 64'(hs_cnt - hs0), 64'd3);
`endif

    // Reset while waiting on the master, then a size=16 request must reprogram.
    xact(6'd16, 34'h0_0000_AAAA, 34'h3_0000_FFFF, 0, 6'd16, 34'h0_0000_FFFF, 1'b1);
    hs0 = hs_cnt;
    xact(6'd16, 34'h0_0000_5555, 34'h2_0000_1234, 1, 6'd16, 34'h0_0000_1234, 1'b0);
    chk("post_reset.hs_count", 64'(hs_cnt - hs0), 64'd1);

    // Counter wrap after 256 completions.
    pulse_reset("pre_wrap");
    for (int i = 0; i < 256; i++) begin
      sz = 6'($urandom_range(63, 0));
      r  = 34'({$urandom(), $urandom()});
      xact(sz, 34'(i), r, 0, eff_f(sz), mask_f(r, eff_f(sz)), 1'b0);
    end
    chk("wrap.count_zero", 64'(xact_count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
